// File: rtl/lcd_num_display.sv
// ---------------------------------------------------------------------------
// lcd_num_display
//
// Shows an unsigned binary value as a field of decimal digits on an RGB LCD.
// A binary-to-BCD converter (double dabble, one bit per pixel clock) runs once
// per frame_start. Its result is copied to the displayed digit register in a
// single COMMIT cycle, so a frame never shows a half-converted number.
// A two-stage pixel pipeline turns the current pixel coordinate into a colour.
// The colour comes from a 16x32 seven-segment style glyph ROM, with optional
// leading-zero blanking and frame-counted blinking.
//
// Ports
//   lcd_pclk     in   pixel clock, all state changes on its rising edge
//   sys_rst      in   asynchronous active-high reset
//   value        in   unsigned number to display (DATA_W bits)
//   frame_start  in   one-cycle pulse at the start of each frame
//   blink_en     in   1 = blink the digit field
//   pixel_xpos   in   current pixel column (11 bits)
//   pixel_ypos   in   current pixel row (11 bits)
//   pixel_data   out  RGB888 colour, two cycles after the coordinate
//   busy         out  conversion in progress (CONV or COMMIT)
//   ovf          out  last committed value exceeded 10^NUM_DIGITS-1
// ---------------------------------------------------------------------------
module lcd_num_display #(
   parameter int          NUM_DIGITS   = 8,
   parameter int          DATA_W       = 27,
   parameter logic [10:0] POS_X        = 11'd1,
   parameter logic [10:0] POS_Y        = 11'd1,
   parameter int          SCALE        = 1,
   parameter int          LZB          = 1,
   parameter int          BLINK_FRAMES = 30,
   parameter logic [23:0] FG_COLOR     = 24'h000000,
   parameter logic [23:0] BG_COLOR     = 24'hFFFFFF
) (
   input  logic              lcd_pclk,
   input  logic              sys_rst,
   input  logic [DATA_W-1:0] value,
   input  logic              frame_start,
   input  logic              blink_en,
   input  logic [10:0]       pixel_xpos,
   input  logic [10:0]       pixel_ypos,
   output logic [23:0]       pixel_data,
   output logic              busy,
   output logic              ovf
);

   localparam int          BCD_W   = NUM_DIGITS * 4;
   localparam int          CNT_W   = $clog2(DATA_W + 1);
   localparam int          BLK_W   = $clog2(BLINK_FRAMES + 1);
   localparam int          SH      = (SCALE == 2) ? 1 : 0;
   localparam logic [11:0] FIELD_W = 12'(NUM_DIGITS * 16 * SCALE);
   localparam logic [11:0] FIELD_H = 12'(32 * SCALE);

   function automatic logic [63:0] max_value(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p - 64'd1;
   endfunction

   localparam logic [63:0] MAX_VAL = max_value(NUM_DIGITS);

   // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
   function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      return r;
   endfunction

   // Glyph ROM: 16-bit row r of glyph g, bit 15 is the leftmost pixel.
   // Glyphs are built from seven rectangular segments; index 10 (and any
   // other code) is the blank glyph.
   function automatic logic [15:0] glyph_row(input logic [3:0] g, input logic [4:0] r);
      logic [6:0]  seg;   // {a,b,c,d,e,f,g}
      logic [15:0] row;
      case (g)
         4'd0:    seg = 7'b1111110;
         4'd1:    seg = 7'b0110000;
         4'd2:    seg = 7'b1101101;
         4'd3:    seg = 7'b1111001;
         4'd4:    seg = 7'b0110011;
         4'd5:    seg = 7'b1011011;
         4'd6:    seg = 7'b1011111;
         4'd7:    seg = 7'b1110000;
         4'd8:    seg = 7'b1111111;
         4'd9:    seg = 7'b1111011;
         default: seg = 7'b0000000;
      endcase
      row = 16'h0000;
      if (seg[6] && r >= 5'd2  && r <= 5'd4)  row = row | 16'h1FF8; // a: cols 3..12
      if (seg[5] && r >= 5'd3  && r <= 5'd15) row = row | 16'h001C; // b: cols 11..13
      if (seg[4] && r >= 5'd16 && r <= 5'd28) row = row | 16'h001C; // c: cols 11..13
      if (seg[3] && r >= 5'd27 && r <= 5'd29) row = row | 16'h1FF8; // d: cols 3..12
      if (seg[2] && r >= 5'd16 && r <= 5'd28) row = row | 16'h3800; // e: cols 2..4
      if (seg[1] && r >= 5'd3  && r <= 5'd15) row = row | 16'h3800; // f: cols 2..4
      if (seg[0] && r >= 5'd14 && r <= 5'd16) row = row | 16'h1FF8; // g: cols 3..12
      return row;
   endfunction

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
   logic              ovf_pend_q, ovf_pend_d;
   logic [BCD_W-1:0]  digits_q, digits_d;
   logic              ovf_q, ovf_d;
   logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic              blink_ph_q, blink_ph_d;

   // ---------------- conversion FSM and blink counter ----------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      bcd_d       = bcd_q;
      ovf_pend_d  = ovf_pend_q;
      digits_d    = digits_q;
      ovf_d       = ovf_q;
      blink_cnt_d = blink_cnt_q;
      blink_ph_d  = blink_ph_q;
      bcd_adj     = dd_adjust(bcd_q);

      case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d    = CONV;
               shift_d    = value;
               bcd_d      = '0;
               cnt_d      = '0;
               ovf_pend_d = (64'(value) > MAX_VAL);
            end
         end
         CONV: begin
            // Bits shifted out of the top BCD nibble only occur for
            // overflowing values, whose BCD result is discarded anyway.
            bcd_d   = BCD_W'({bcd_adj, shift_q[DATA_W-1]});
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) state_d = COMMIT;
         end
         COMMIT: begin
            digits_d = ovf_pend_q ? {NUM_DIGITS{4'h9}} : bcd_q;
            ovf_d    = ovf_pend_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (frame_start) begin
         if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BLK_W'(1);
         end
      end
   end

   always_ff @(posedge lcd_pclk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         bcd_q       <= '0;
         ovf_pend_q  <= 1'b0;
         digits_q    <= '0;
         ovf_q       <= 1'b0;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         bcd_q       <= bcd_d;
         ovf_pend_q  <= ovf_pend_d;
         digits_q    <= digits_d;
         ovf_q       <= ovf_d;
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
      end
   end

   // ---------------- pixel stage p0: coordinate decode ---------------------
   logic [11:0] rx, ry;
   logic [7:0]  u;
   logic [4:0]  v;
   logic        in_field_d;

   always_comb begin
      // A coordinate left of / above the field wraps to a large value and so
      // fails the range test without a separate lower-bound compare.
      rx         = {1'b0, pixel_xpos} - {1'b0, POS_X};
      ry         = {1'b0, pixel_ypos} - {1'b0, POS_Y};
      in_field_d = (rx < FIELD_W) && (ry < FIELD_H);
      u          = 8'(rx >> SH);
      v          = 5'(ry >> SH);
   end

   logic       in_field_p0_q;
   logic       blink_en_p0_q;
   logic [3:0] dig_p0_q;
   logic [3:0] col_p0_q;
   logic [4:0] row_p0_q;

   always_ff @(posedge lcd_pclk or posedge sys_rst) begin
      if (sys_rst) begin
         in_field_p0_q <= 1'b0;
         blink_en_p0_q <= 1'b0;
         dig_p0_q      <= '0;
         col_p0_q      <= '0;
         row_p0_q      <= '0;
      end else begin
         in_field_p0_q <= in_field_d;
         blink_en_p0_q <= blink_en;
         dig_p0_q      <= u[7:4];
         col_p0_q      <= u[3:0];
         row_p0_q      <= v;
      end
   end

   // ---------------- pixel stage p1: glyph lookup and colour ---------------
   logic [3:0]  disp [NUM_DIGITS];   // glyph index per position, 0 = MSD
   logic [3:0]  glyph;
   logic [15:0] grow;
   logic        show;
   logic [23:0] pix_d;
   logic [23:0] pix_p1_q;

   always_comb begin
      logic lead;
      lead = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         disp[i] = digits_q[(NUM_DIGITS-1-i)*4 +: 4];
         lead    = lead && (disp[i] == 4'd0);
         if (LZB != 0 && lead && i != NUM_DIGITS-1) disp[i] = 4'd10;
      end
      glyph = 4'd10;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (dig_p0_q == 4'(i)) glyph = disp[i];
      grow  = glyph_row(glyph, row_p0_q);
      show  = in_field_p0_q && !(blink_en_p0_q && !blink_ph_q) && grow[4'd15 - col_p0_q];
      pix_d = show ? FG_COLOR : BG_COLOR;
   end

   always_ff @(posedge lcd_pclk or posedge sys_rst) begin
      if (sys_rst) pix_p1_q <= BG_COLOR;
      else         pix_p1_q <= pix_d;
   end

   assign pixel_data = pix_p1_q;
   assign busy       = (state_q != IDLE);
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_lcd_num_display.sv
`timescale 1ns/1ps
module tb_lcd_num_display;

   localparam int          ND   = 8;
   localparam int          DW   = 27;
   localparam logic [23:0] FG   = 24'h102030;
   localparam logic [23:0] BG   = 24'hF0E0D0;
   localparam int          AX   = 5;
   localparam int          AY   = 3;
   localparam int          BX   = 40;
   localparam int          BY   = 7;
   localparam int          BF_A = 2;
   localparam int          BF_B = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] value = '0;
   logic          frame_start = 1'b0;
   logic          blink_en = 1'b0;
   logic [10:0]   px = '0;
   logic [10:0]   py = '0;
   logic [23:0]   pix_a, pix_b;
   logic          busy_a, busy_b, ovf_a, ovf_b;

   always #5 clk = ~clk;

   // A: scale 1, leading-zero blanking, blink every 2 frames
   lcd_num_display #(.NUM_DIGITS(ND), .DATA_W(DW), .POS_X(11'(AX)), .POS_Y(11'(AY)),
      .SCALE(1), .LZB(1), .BLINK_FRAMES(BF_A), .FG_COLOR(FG), .BG_COLOR(BG)) dut_a (
      .lcd_pclk(clk), .sys_rst(rst), .value(value), .frame_start(frame_start),
      .blink_en(blink_en), .pixel_xpos(px), .pixel_ypos(py),
      .pixel_data(pix_a), .busy(busy_a), .ovf(ovf_a));

   // B: scale 2, no blanking, blink every 3 frames
   lcd_num_display #(.NUM_DIGITS(ND), .DATA_W(DW), .POS_X(11'(BX)), .POS_Y(11'(BY)),
      .SCALE(2), .LZB(0), .BLINK_FRAMES(BF_B), .FG_COLOR(FG), .BG_COLOR(BG)) dut_b (
      .lcd_pclk(clk), .sys_rst(rst), .value(value), .frame_start(frame_start),
      .blink_en(blink_en), .pixel_xpos(px), .pixel_ypos(py),
      .pixel_data(pix_b), .busy(busy_b), .ovf(ovf_b));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- scoreboard ----------------
   // kind 0 = pixel colour, 1 = busy, 2 = ovf; due = cycle whose posedge
   // must have produced the value.
   typedef struct {
      int          due;
      int          kind;
      logic [23:0] ea;
      logic [23:0] eb;
      string       nm;
   } exp_t;

   exp_t sb[$];

   task automatic push(input int due, input int kind, input logic [23:0] ea,
                       input logic [23:0] eb, input string nm);
      exp_t e;
      e.due = due; e.kind = kind; e.ea = ea; e.eb = eb; e.nm = nm;
      sb.push_back(e);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due < cyc) begin
               total++; bad++;
               $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", sb[i].nm, sb[i].due, cyc);
               sb.delete(i);
            end else if (sb[i].due == cyc) begin
               case (sb[i].kind)
                  0: begin
                     check({sb[i].nm, "_pix_a"}, pix_a, sb[i].ea);
                     check({sb[i].nm, "_pix_b"}, pix_b, sb[i].eb);
                  end
                  1: begin
                     check({sb[i].nm, "_busy_a"}, {23'b0, busy_a}, sb[i].ea);
                     check({sb[i].nm, "_busy_b"}, {23'b0, busy_b}, sb[i].eb);
                  end
                  default: begin
                     check({sb[i].nm, "_ovf_a"}, {23'b0, ovf_a}, sb[i].ea);
                     check({sb[i].nm, "_ovf_b"}, {23'b0, ovf_b}, sb[i].eb);
                  end
               endcase
               sb.delete(i);
            end
         end
      end
   end

   // ---------------- reference model ----------------
   int     m_dig [ND];     // displayed digits, index 0 = most significant
   bit     m_ovf;
   int     m_bcnt [2];
   bit     m_bph [2];
   int     m_free;         // first cycle at which a frame_start is accepted
   bit     m_pend;
   longint m_pval;
   int     m_pdue;
   longint maxv;

   function automatic longint pow10(input int n);
      longint p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   function automatic string segs_of(input int g);
      case (g)
         0: return "abcdef";
         1: return "bc";
         2: return "abdeg";
         3: return "abcdg";
         4: return "bcfg";
         5: return "acdfg";
         6: return "acdefg";
         7: return "abc";
         8: return "abcdefg";
         9: return "abcdfg";
         default: return "";
      endcase
   endfunction

   function automatic bit in_seg(input byte s, input int c, input int r);
      case (s)
         "a": return c >= 3  && c <= 12 && r >= 2  && r <= 4;
         "b": return c >= 11 && c <= 13 && r >= 3  && r <= 15;
         "c": return c >= 11 && c <= 13 && r >= 16 && r <= 28;
         "d": return c >= 3  && c <= 12 && r >= 27 && r <= 29;
         "e": return c >= 2  && c <= 4  && r >= 16 && r <= 28;
         "f": return c >= 2  && c <= 4  && r >= 3  && r <= 15;
         "g": return c >= 3  && c <= 12 && r >= 14 && r <= 16;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit glyph_on(input int g, input int c, input int r);
      string s;
      s = segs_of(g);
      for (int i = 0; i < s.len(); i++)
         if (in_seg(s[i], c, r)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [23:0] exp_pix(input int inst, input int x, input int y);
      int ox, oy, sc, u, r, d, c;
      bit lead;
      ox = (inst == 0) ? AX : BX;
      oy = (inst == 0) ? AY : BY;
      sc = (inst == 0) ? 1 : 2;
      if (x < ox || y < oy || x >= ox + ND * 16 * sc || y >= oy + 32 * sc) return BG;
      if (blink_en && !m_bph[inst]) return BG;
      u = (x - ox) / sc;
      r = (y - oy) / sc;
      d = u / 16;
      c = u % 16;
      if (inst == 0 && d < ND - 1) begin
         lead = 1'b1;
         for (int i = 0; i <= d; i++) if (m_dig[i] != 0) lead = 1'b0;
         if (lead) return BG;
      end
      return glyph_on(m_dig[d], c, r) ? FG : BG;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ND; i++) m_dig[i] = 0;
      m_ovf = 1'b0;
      m_bcnt[0] = 0; m_bcnt[1] = 0;
      m_bph[0] = 1'b1; m_bph[1] = 1'b1;
      m_free = 0;
      m_pend = 1'b0;
   endtask

   task automatic model_sync();
      if (m_pend && cyc >= m_pdue) begin
         m_pend = 1'b0;
         m_ovf  = (m_pval > maxv);
         for (int d = 0; d < ND; d++)
            m_dig[d] = m_ovf ? 9 : int'((m_pval / pow10(ND - 1 - d)) % 10);
      end
   endtask

   // ---------------- stimulus helpers (called on a falling edge) ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      model_sync();
   endtask

   task automatic frame(input longint v);
      int k;
      int bf;
      bit ovf_new;
      k = cyc;
      value = DW'(v);
      frame_start = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bf = (i == 0) ? BF_A : BF_B;
         if (m_bcnt[i] == bf - 1) begin
            m_bcnt[i] = 0;
            m_bph[i]  = ~m_bph[i];
         end else begin
            m_bcnt[i]++;
         end
      end
      if (k >= m_free) begin
         m_free  = k + DW + 2;
         m_pend  = 1'b1;
         m_pval  = v;
         m_pdue  = k + DW + 2;
         ovf_new = (v > maxv);
         for (int j = 1; j <= DW + 2; j++)
            push(k + j, 1, 24'(j <= DW + 1), 24'(j <= DW + 1), "busy");
         push(k + DW + 1, 2, 24'(m_ovf), 24'(m_ovf), "ovf_hold");
         push(k + DW + 2, 2, 24'(ovf_new), 24'(ovf_new), "ovf_commit");
      end
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic put_pixel(input int x, input int y, input string nm);
      px = 11'(x);
      py = 11'(y);
      push(cyc + 2, 0, exp_pix(0, x, y), exp_pix(1, x, y), nm);
      @(negedge clk);
   endtask

   task automatic pixel_burst(input int n, input string nm);
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 2))
            0:       put_pixel(AX + int'($urandom_range(0, ND * 16 - 1)), AY + int'($urandom_range(0, 31)), nm);
            1:       put_pixel(BX + int'($urandom_range(0, ND * 32 - 1)), BY + int'($urandom_range(0, 63)), nm);
            default: put_pixel(int'($urandom_range(0, 320)), int'($urandom_range(0, 80)), nm);
         endcase
      end
   endtask

   task automatic convert_and_show(input longint v, input int n, input string nm);
      frame(v);
      idle(32);
      pixel_burst(n, nm);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      maxv = pow10(ND) - 1;
      model_reset();

      // reset state
      repeat (3) @(negedge clk);
      check("rst_pix_a",  pix_a, BG);
      check("rst_pix_b",  pix_b, BG);
      check("rst_busy_a", {23'b0, busy_a}, 24'h0);
      check("rst_ovf_b",  {23'b0, ovf_b}, 24'h0);
      rst = 1'b0;
      idle(2);
      pixel_burst(30, "zero");

      // 12345 with blanking of leading zeros; segment a of digits 0-2 must stay BG on A
      frame(12345);
      idle(32);
      for (int d = 0; d < 3; d++) put_pixel(AX + d * 16 + 7, AY + 3, "lzb");
      put_pixel(AX + 7 * 16 + 7, AY + 15, "lsd5_g");
      pixel_burst(150, "v12345");

      // overflow and the largest representable value
      convert_and_show(100000000, 120, "ovf");
      convert_and_show(99999999, 100, "max");

      // leading digit 1: glyph row 12 around column 4 and column 12
      frame(12345678);
      idle(32);
      put_pixel(AX + 4,  AY + 12, "d0_c4_r12");
      put_pixel(BX + 9,  BY + 25, "d0_c4_r12_s2");
      put_pixel(AX + 12, AY + 12, "d0_c12_r12");
      put_pixel(BX + 25, BY + 24, "d0_c12_r12_s2");
      pixel_burst(60, "v12345678");

      // second frame_start during conversion with a new value is ignored
      frame(4096001);
      idle(5);
      frame(7);
      idle(32);
      pixel_burst(120, "ignored");

      // random values (some overflow) and corner values
      for (int i = 0; i < 6; i++)
         convert_and_show(longint'($urandom_range(0, (1 << DW) - 1)), 80, "rand");
      convert_and_show(0, 60, "v0");
      convert_and_show(10000000, 60, "v1e7");

      // blinking over eight frames
      convert_and_show(88888888, 20, "v8s");
      blink_en = 1'b1;
      idle(3);
      for (int i = 0; i < 8; i++) begin
         frame(88888888);
         idle(32);
         put_pixel(AX + 119, AY + 15, "blink_a_g");
         put_pixel(BX + 238, BY + 30, "blink_b_g");
         pixel_burst(15, "blink");
      end
      blink_en = 1'b0;
      idle(3);

      // reset in the middle of a conversion
      px = 11'(AX + 119);
      py = 11'(AY + 15);
      frame(5555);
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_busy_a", {23'b0, busy_a}, 24'h0);
      check("midrst_busy_b", {23'b0, busy_b}, 24'h0);
      check("midrst_pix_a",  pix_a, BG);
      check("midrst_pix_b",  pix_b, BG);
      check("midrst_ovf_a",  {23'b0, ovf_a}, 24'h0);
      sb.delete();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 35; i++) begin
         push(cyc + 1, 1, 24'h0, 24'h0, "busy_after_rst");
         @(negedge clk);
      end
      idle(1);
      pixel_burst(60, "after_rst");

      // first conversion after reset runs normally
      convert_and_show(424242, 80, "post_rst");

      // drain the scoreboard with a bounded wait
      for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
      while (sb.size() > 0) begin
         total++; bad++;
         $display("FAIL %s: expectation for cycle %0d never reached", sb[0].nm, sb[0].due);
         sb.delete(0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
